// File: rtl/rq_pkt_arbiter.sv
// rq_pkt_arbiter
// Packet-atomic round-robin arbiter that merges the DMA read-request and
// write-request channels onto one registered RQ stream feeding the RQ
// clock-crossing FIFO. Runs entirely in the DMA clock domain.
//
// Ports:
//   clk, rst            DMA clock, synchronous active-high reset
//   rd_axis_rq_*        read-request channel in (valid/last/data/user/keep), ready out
//   wr_axis_rq_*        write-request channel in (valid/last/data/user/keep), ready out
//   dma_axis_rq_*       merged RQ stream out (valid/last/data/user/keep), ready in
//   rd_pkt_cnt          read packets accepted (wraps)
//   wr_pkt_cnt          write packets accepted (wraps)
//   arb_state           debug: 0 IDLE, 1 RD_PKT, 2 WR_PKT
module rq_pkt_arbiter #(
  parameter int DATA_W  = 256,
  parameter int KEEP_W  = 8,
  parameter int TUSER_W = 60,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_axis_rq_tvalid,
  input  logic               rd_axis_rq_tlast,
  input  logic [DATA_W-1:0]  rd_axis_rq_tdata,
  input  logic [TUSER_W-1:0] rd_axis_rq_tuser,
  input  logic [KEEP_W-1:0]  rd_axis_rq_tkeep,
  output logic               rd_axis_rq_tready,
  input  logic               wr_axis_rq_tvalid,
  input  logic               wr_axis_rq_tlast,
  input  logic [DATA_W-1:0]  wr_axis_rq_tdata,
  input  logic [TUSER_W-1:0] wr_axis_rq_tuser,
  input  logic [KEEP_W-1:0]  wr_axis_rq_tkeep,
  output logic               wr_axis_rq_tready,
  output logic               dma_axis_rq_tvalid,
  output logic               dma_axis_rq_tlast,
  output logic [DATA_W-1:0]  dma_axis_rq_tdata,
  output logic [TUSER_W-1:0] dma_axis_rq_tuser,
  output logic [KEEP_W-1:0]  dma_axis_rq_tkeep,
  input  logic               dma_axis_rq_tready,
  output logic [CNT_W-1:0]   rd_pkt_cnt,
  output logic [CNT_W-1:0]   wr_pkt_cnt,
  output logic [1:0]         arb_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               last_wr_q;          // 1: last completed packet was WR
  logic               out_valid_q;
  logic               out_last_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [TUSER_W-1:0] out_user_q;
  logic [KEEP_W-1:0]  out_keep_q;
  logic [CNT_W-1:0]   rd_cnt_q, wr_cnt_q;

  logic grant_rd, grant_wr;
  logic slot_free;
  logic accept;
  logic beat_last;

  // The output slot can take a new beat when it is empty or draining now.
  assign slot_free = !out_valid_q || dma_axis_rq_tready;

  // Combinational grant so an IDLE winner is accepted in the same cycle.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_axis_rq_tvalid && (!wr_axis_rq_tvalid || last_wr_q)) begin
          grant_rd = 1'b1;
        end else if (wr_axis_rq_tvalid) begin
          grant_wr = 1'b1;
        end
      end
      ST_RD:   grant_rd = 1'b1;
      ST_WR:   grant_wr = 1'b1;
      default: ;
    endcase
  end

  assign rd_axis_rq_tready = slot_free && grant_rd;
  assign wr_axis_rq_tready = slot_free && grant_wr;

  assign accept    = (rd_axis_rq_tready && rd_axis_rq_tvalid) ||
                     (wr_axis_rq_tready && wr_axis_rq_tvalid);
  assign beat_last = grant_wr ? wr_axis_rq_tlast : rd_axis_rq_tlast;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (beat_last) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        state_d = grant_wr ? ST_WR : ST_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_wr_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_keep_q  <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept && beat_last) begin
        last_wr_q <= grant_wr;
        if (grant_wr) wr_cnt_q <= wr_cnt_q + 1'b1;
        else          rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      // Register only moves when the slot is free; otherwise it holds.
      if (slot_free) begin
        if (accept) begin
          out_valid_q <= 1'b1;
          out_last_q  <= beat_last;
          out_data_q  <= grant_wr ? wr_axis_rq_tdata : rd_axis_rq_tdata;
          out_user_q  <= grant_wr ? wr_axis_rq_tuser : rd_axis_rq_tuser;
          out_keep_q  <= grant_wr ? wr_axis_rq_tkeep : rd_axis_rq_tkeep;
        end else begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
          out_user_q  <= '0;
          out_keep_q  <= '0;
        end
      end
    end
  end

  assign dma_axis_rq_tvalid = out_valid_q;
  assign dma_axis_rq_tlast  = out_last_q;
  assign dma_axis_rq_tdata  = out_data_q;
  assign dma_axis_rq_tuser  = out_user_q;
  assign dma_axis_rq_tkeep  = out_keep_q;
  assign rd_pkt_cnt         = rd_cnt_q;
  assign wr_pkt_cnt         = wr_cnt_q;
  assign arb_state          = state_q;

endmodule

// File: tb/tb_rq_pkt_arbiter.sv
// tb_rq_pkt_arbiter
// Directed bench for rq_pkt_arbiter: one task per scenario, inline checks
// against hand-computed values, one summary line at the end.
module tb_rq_pkt_arbiter;
  localparam int DATA_W  = 256;
  localparam int KEEP_W  = 8;
  localparam int TUSER_W = 60;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               rd_v, rd_l, rd_r;
  logic [DATA_W-1:0]  rd_d;
  logic [TUSER_W-1:0] rd_u;
  logic [KEEP_W-1:0]  rd_k;
  logic               wr_v, wr_l, wr_r;
  logic [DATA_W-1:0]  wr_d;
  logic [TUSER_W-1:0] wr_u;
  logic [KEEP_W-1:0]  wr_k;
  logic               o_v, o_l, o_r;
  logic [DATA_W-1:0]  o_d;
  logic [TUSER_W-1:0] o_u;
  logic [KEEP_W-1:0]  o_k;
  logic [CNT_W-1:0]   rd_cnt, wr_cnt;
  logic [1:0]         st;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rq_pkt_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUSER_W(TUSER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_axis_rq_tvalid(rd_v), .rd_axis_rq_tlast(rd_l), .rd_axis_rq_tdata(rd_d),
    .rd_axis_rq_tuser(rd_u), .rd_axis_rq_tkeep(rd_k), .rd_axis_rq_tready(rd_r),
    .wr_axis_rq_tvalid(wr_v), .wr_axis_rq_tlast(wr_l), .wr_axis_rq_tdata(wr_d),
    .wr_axis_rq_tuser(wr_u), .wr_axis_rq_tkeep(wr_k), .wr_axis_rq_tready(wr_r),
    .dma_axis_rq_tvalid(o_v), .dma_axis_rq_tlast(o_l), .dma_axis_rq_tdata(o_d),
    .dma_axis_rq_tuser(o_u), .dma_axis_rq_tkeep(o_k), .dma_axis_rq_tready(o_r),
    .rd_pkt_cnt(rd_cnt), .wr_pkt_cnt(wr_cnt), .arb_state(st)
  );

  // Advance one clock and settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_v = 0; rd_l = 0; rd_d = '0; rd_u = '0; rd_k = '0;
    wr_v = 0; wr_l = 0; wr_d = '0; wr_u = '0; wr_k = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    o_r = 1'b1;
    do_reset();
    n_checks++;
    if ({o_v, o_l, o_d, o_u, o_k} !== '0) begin
      n_fail++; $display("FAIL reset_out: got v=%b l=%b d=%h", o_v, o_l, o_d);
    end
    n_checks++;
    if (st !== 2'd0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_state: got st=%0d rd=%0d wr=%0d want 0/0/0", st, rd_cnt, wr_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    rd_v = 1; rd_l = 1; rd_d = {32{8'hA5}}; rd_k = 8'h0F; rd_u = 60'hFF;
    #1;
    n_checks++;
    if (rd_r !== 1'b1 || wr_r !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got rd_r=%b wr_r=%b want 1/0", rd_r, wr_r);
    end
    step();
    idle_inputs();
    n_checks++;
    if (o_v !== 1'b1 || o_l !== 1'b1 || o_d !== {32{8'hA5}} || o_k !== 8'h0F || o_u !== 60'hFF) begin
      n_fail++; $display("FAIL single_beat: got v=%b l=%b k=%h u=%h d=%h", o_v, o_l, o_k, o_u, o_d);
    end
    n_checks++;
    if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL single_cnt: got rd=%0d wr=%0d want 1/0", rd_cnt, wr_cnt);
    end
    step();
    n_checks++;
    if (o_v !== 1'b0 || o_d !== '0) begin
      n_fail++; $display("FAIL single_drain: got v=%b d=%h want 0/0", o_v, o_d);
    end
    $display("test_single done");
  endtask

  task automatic test_alternate();
    do_reset();
    rd_v = 1; rd_l = 1; rd_d = 256'h1;
    wr_v = 1; wr_l = 1; wr_d = 256'h2;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (rd_r !== (i % 2 == 0) || wr_r !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL alt_ready[%0d]: got rd_r=%b wr_r=%b", i, rd_r, wr_r);
      end
      step();
      n_checks++;
      if (o_v !== 1'b1 || o_d !== ((i % 2 == 0) ? 256'h1 : 256'h2)) begin
        n_fail++; $display("FAIL alt_out[%0d]: got v=%b d=%h", i, o_v, o_d);
      end
    end
    idle_inputs();
    n_checks++;
    if (rd_cnt !== 16'd4 || wr_cnt !== 16'd4) begin
      n_fail++; $display("FAIL alt_cnt: got rd=%0d wr=%0d want 4/4", rd_cnt, wr_cnt);
    end
    step();
    $display("test_alternate done");
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      wr_v = 1; wr_l = (i == 3); wr_d = 256'h100 + i;
      if (i == 1) begin rd_v = 1; rd_l = 1; rd_d = 256'h200; end
      #1;
      n_checks++;
      if (wr_r !== 1'b1 || rd_r !== 1'b0) begin
        n_fail++; $display("FAIL lock_ready[%0d]: got wr_r=%b rd_r=%b want 1/0", i, wr_r, rd_r);
      end
      step();
      n_checks++;
      if (o_v !== 1'b1 || o_d !== 256'h100 + i || o_l !== (i == 3)) begin
        n_fail++; $display("FAIL lock_out[%0d]: got v=%b l=%b d=%h", i, o_v, o_l, o_d);
      end
    end
    wr_v = 0; wr_l = 0;
    #1;
    n_checks++;
    if (st !== 2'd0 || rd_r !== 1'b1) begin
      n_fail++; $display("FAIL lock_release: got st=%0d rd_r=%b want 0/1", st, rd_r);
    end
    step();
    idle_inputs();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 256'h200 || o_l !== 1'b1) begin
      n_fail++; $display("FAIL lock_rd_after: got v=%b l=%b d=%h want 1/1/200", o_v, o_l, o_d);
    end
    n_checks++;
    if (rd_cnt !== 16'd5 || wr_cnt !== 16'd5) begin
      n_fail++; $display("FAIL lock_cnt: got rd=%0d wr=%0d want 5/5", rd_cnt, wr_cnt);
    end
    step();
    $display("test_lock done");
  endtask

  task automatic test_stall();
    wr_v = 1; wr_l = 0; wr_d = 256'h300; wr_k = 8'hAA; wr_u = 60'h33;
    step();
    o_r = 0;
    wr_d = 256'h301; wr_k = 8'h55; wr_u = 60'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (o_v !== 1'b1 || o_d !== 256'h300 || o_k !== 8'hAA || o_u !== 60'h33 || o_l !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b l=%b k=%h u=%h d=%h", i, o_v, o_l, o_k, o_u, o_d);
      end
      n_checks++;
      if (wr_r !== 1'b0 || rd_r !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got wr_r=%b rd_r=%b want 0/0", i, wr_r, rd_r);
      end
      step();
    end
    o_r = 1;
    step();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 256'h301 || o_k !== 8'h55 || o_l !== 1'b0) begin
      n_fail++; $display("FAIL stall_resume: got v=%b l=%b d=%h want 1/0/301", o_v, o_l, o_d);
    end
    wr_d = 256'h302; wr_l = 1;
    step();
    idle_inputs();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 256'h302 || o_l !== 1'b1 || wr_cnt !== 16'd6) begin
      n_fail++; $display("FAIL stall_last: got v=%b l=%b d=%h wr=%0d want 1/1/302/6", o_v, o_l, o_d, wr_cnt);
    end
    step();
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++; $display("FAIL stall_dup: got v=%b want 0", o_v);
    end
    $display("test_stall done");
  endtask

  task automatic test_reset_mid();
    wr_v = 1; wr_l = 0; wr_d = 256'h400; wr_k = 8'hFF; wr_u = 60'h7;
    step();
    wr_d = 256'h401;
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    n_checks++;
    if ({o_v, o_l, o_d, o_u, o_k} !== '0 || st !== 2'd0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midrst: got v=%b l=%b st=%0d rd=%0d wr=%0d d=%h", o_v, o_l, st, rd_cnt, wr_cnt, o_d);
    end
    rd_v = 1; rd_l = 1; rd_d = 256'h500;
    wr_v = 1; wr_l = 1; wr_d = 256'h600;
    #1;
    n_checks++;
    if (rd_r !== 1'b1 || wr_r !== 1'b0) begin
      n_fail++; $display("FAIL midrst_tie: got rd_r=%b wr_r=%b want 1/0", rd_r, wr_r);
    end
    step();
    idle_inputs();
    n_checks++;
    if (o_v !== 1'b1 || o_d !== 256'h500) begin
      n_fail++; $display("FAIL midrst_first: got v=%b d=%h want 1/500", o_v, o_d);
    end
    step();
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    do_reset();
    rd_v = 1; rd_l = 1; rd_d = 256'h7;
    for (int i = 0; i < 65535; i++) step();
    n_checks++;
    if (rd_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max: got rd=%h want ffff", rd_cnt);
    end
    step();
    idle_inputs();
    n_checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_zero: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
    end
    step();
    $display("test_wrap done");
  endtask

  initial begin
    rst = 1'b0;
    o_r = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
